// File: rtl/conway_board_ctrl_if.sv
// -----------------------------------------------------------------------------
// conway_board_ctrl_if
//   Groups the user-control requests and the board-facing outputs of
//   conway_board_ctrl into one bundle.
//   master : the user/controller side (drives requests, observes the board)
//   slave  : conway_board_ctrl itself
//   Signals:
//     run_req     1-cycle pulse, toggle RUN/PAUSE
//     step_req    1-cycle pulse, advance one generation while paused
//     reload_req  1-cycle pulse, reload board from state_0
//     gen_limit   stop generation (only honoured when GEN_LIMIT_EN is defined)
//     board_rst   shared cell reset
//     board_ena   shared cell enable, one pulse per generation
//     state       LOAD=0, PAUSE=1, RUN=2, DONE=3
//     generation  generations since last load (wraps)
//     done        high while in DONE
// -----------------------------------------------------------------------------
interface conway_board_ctrl_if #(
    parameter int GEN_W = 16
);
    logic             run_req;
    logic             step_req;
    logic             reload_req;
    logic [GEN_W-1:0] gen_limit;
    logic             board_rst;
    logic             board_ena;
    logic [1:0]       state;
    logic [GEN_W-1:0] generation;
    logic             done;

    modport master (
        output run_req, step_req, reload_req, gen_limit,
        input  board_rst, board_ena, state, generation, done
    );

    modport slave (
        input  run_req, step_req, reload_req, gen_limit,
        output board_rst, board_ena, state, generation, done
    );
endinterface

// File: rtl/conway_board_ctrl.sv
// -----------------------------------------------------------------------------
// conway_board_ctrl
//   Sequencer for the conway_cell board. Holds the shared board reset while
//   loading state_0, then either single-steps or free-runs the board by
//   pulsing the shared enable, and counts generations.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    conway_board_ctrl_if.slave (requests in, board_rst/board_ena/
//            state/generation/done out; all outputs registered)
//   Parameters:
//     TICKS_PER_STEP  clk cycles between generations in RUN (>=1)
//     LOAD_CYCLES     cycles board_rst is held in LOAD (>=1)
//     GEN_W           generation counter width
//   Optional feature (macro GEN_LIMIT_EN):
//     defined   - reaching a nonzero gen_limit moves to DONE one cycle after
//                 the generation's enable pulse; only reload_req/rst_n leave.
//     undefined - gen_limit ignored, done tied low, DONE unreachable.
// -----------------------------------------------------------------------------
module conway_board_ctrl #(
    parameter int TICKS_PER_STEP = 1000000,
    parameter int LOAD_CYCLES    = 2,
    parameter int GEN_W          = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    conway_board_ctrl_if.slave bus
);
    localparam int TICK_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int LOAD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_STEP - 1);
    localparam logic [LOAD_W-1:0] LAST_LOAD = LOAD_W'(LOAD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               board_rst_q, board_rst_d;
    logic               board_ena_q, board_ena_d;
    logic [GEN_W-1:0]   generation_q, generation_d;
    logic [LOAD_W-1:0]  load_cnt_q, load_cnt_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic               inc;
    logic               limit_hit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            board_rst_q  <= 1'b1;
            board_ena_q  <= 1'b0;
            generation_q <= '0;
            load_cnt_q   <= '0;
            tick_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            board_rst_q  <= board_rst_d;
            board_ena_q  <= board_ena_d;
            generation_q <= generation_d;
            load_cnt_q   <= load_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        board_rst_d  = 1'b0;
        board_ena_d  = 1'b0;
        generation_d = generation_q;
        load_cnt_d   = load_cnt_q;
        tick_cnt_d   = tick_cnt_q;
        inc          = 1'b0;

        if (bus.reload_req) begin
            // Reload beats every other request and every state.
            state_d      = ST_LOAD;
            board_rst_d  = 1'b1;
            generation_d = '0;
            load_cnt_d   = '0;
            tick_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    board_rst_d = 1'b1;
                    if (load_cnt_q == LAST_LOAD) begin
                        state_d     = ST_PAUSE;
                        board_rst_d = 1'b0;
                        load_cnt_d  = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (limit_hit_q) begin
                        state_d = ST_DONE;
                    end else if (bus.run_req) begin
                        state_d    = ST_RUN;
                        tick_cnt_d = '0;
                    end else if (bus.step_req) begin
                        inc = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (limit_hit_q) begin
                        state_d = ST_DONE;
                    end else if (bus.run_req) begin
                        state_d = ST_PAUSE;
                    end else if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d = '0;
                        inc        = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_DONE;
                end
            endcase
        end

        if (inc) begin
            board_ena_d  = 1'b1;
            generation_d = generation_q + 1'b1;
        end
    end

`ifdef GEN_LIMIT_EN
    logic limit_hit_d;
    logic done_q;

    // The limit is compared against the post-increment value; the pulse that
    // reaches the limit still goes out, DONE follows on the next cycle.
    always_comb begin
        limit_hit_d = inc && (bus.gen_limit != '0) && (generation_d == bus.gen_limit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit_hit_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            limit_hit_q <= limit_hit_d;
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign bus.done = done_q;
`else
    logic unused_gen_limit;
    assign unused_gen_limit = ^bus.gen_limit;
    assign limit_hit_q      = 1'b0;
    assign bus.done         = 1'b0;
`endif

    assign bus.state      = state_q;
    assign bus.board_rst  = board_rst_q;
    assign bus.board_ena  = board_ena_q;
    assign bus.generation = generation_q;
endmodule
